// File: rtl/odometer.sv
// rtl/odometer.sv - wheel sensor sync/debounce, 10 m distance strobe, trip distance and stage flags
module odometer #(
    parameter int          DW               = 32,
    parameter logic [31:0] TICKS_PER_10M    = 32'd8,
    parameter int          SYNC_STAGES      = 2,
    parameter int          DEBOUNCE_CYCLES  = 4,
    parameter logic [31:0] STAGE2_START_10M = 32'd300,
    parameter logic [31:0] STAGE3_START_10M = 32'd1000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wheel_in,
    input  logic          trip_active,
    output logic          pulse_10m,
    output logic [DW-1:0] distance_10m,
    output logic          is_stage_1st,
    output logic          is_stage_2nd,
    output logic          is_stage_3rd,
    output logic          overflow
);

    localparam int             DBW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0]  TICK_LAST = DW'(TICKS_PER_10M - 32'd1);
    localparam logic [DW-1:0]  S2_START  = DW'(STAGE2_START_10M);
    localparam logic [DW-1:0]  S3_START  = DW'(STAGE3_START_10M);
    localparam logic [DW-1:0]  DIST_MAX  = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   d_q;
    logic [DBW-1:0]         db_cnt;
    logic                   tick;
    logic                   trip_q;
    logic                   trip_start;
    logic [DW-1:0]          tick_cnt;
    logic [DW-1:0]          tick_next;
    logic [DW-1:0]          dist_next;
    logic                   ovf_next;
    logic                   pulse_next;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], wheel_in};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q    <= 1'b0;
            db_cnt <= '0;
        end else if (s != d_q) begin
            if (db_cnt == DB_LAST) begin
                d_q    <= s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end else begin
            db_cnt <= '0;
        end
    end

    // A tick is the edge on which the debounced level is about to rise.
    assign tick       = (s != d_q) && (db_cnt == DB_LAST) && s;
    assign trip_start = trip_active & ~trip_q;

    always_comb begin
        tick_next  = tick_cnt;
        dist_next  = distance_10m;
        ovf_next   = overflow;
        pulse_next = 1'b0;
        if (trip_start) begin
            tick_next = '0;
            dist_next = '0;
            ovf_next  = 1'b0;
        end else if (trip_active && tick) begin
            if (tick_cnt < TICK_LAST) begin
                tick_next = tick_cnt + 1'b1;
            end else begin
                tick_next  = '0;
                pulse_next = 1'b1;
                if (distance_10m == DIST_MAX) begin
                    ovf_next = 1'b1;
                end else begin
                    dist_next = distance_10m + 1'b1;
                end
            end
        end
    end

    // Flags derive from the next distance so they move on the same edge as distance_10m.
    always_ff @(posedge clk) begin
        if (rst) begin
            trip_q       <= 1'b0;
            tick_cnt     <= '0;
            distance_10m <= '0;
            overflow     <= 1'b0;
            pulse_10m    <= 1'b0;
            is_stage_1st <= 1'b1;
            is_stage_2nd <= 1'b0;
            is_stage_3rd <= 1'b0;
        end else begin
            trip_q       <= trip_active;
            tick_cnt     <= tick_next;
            distance_10m <= dist_next;
            overflow     <= ovf_next;
            pulse_10m    <= pulse_next;
            is_stage_1st <= (dist_next < S2_START);
            is_stage_2nd <= (dist_next >= S2_START) && (dist_next < S3_START);
            is_stage_3rd <= (dist_next >= S3_START);
        end
    end

endmodule
